gn_axis_upsizer: RTL and testbench



---
 rtl/gn_axis_upsizer.sv | 108 ++++++++++
 tb/tb_gn_axis_upsizer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gn_axis_upsizer.sv
// AXI-Stream width up-converter: packs narrow slave beats little-endian into one
// wide master word, closing early on tlast with tkeep marking the filled lanes.
module gn_axis_upsizer #(
    parameter int P_S_AXIS_DWIDTH = 8,
    parameter int P_M_AXIS_DWIDTH = 32,
    localparam int R  = P_M_AXIS_DWIDTH / P_S_AXIS_DWIDTH,
    localparam int CW = (R > 1) ? $clog2(R) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [P_S_AXIS_DWIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [P_M_AXIS_DWIDTH-1:0] m_axis_tdata,
    output logic [R-1:0]               m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast
);

    logic [P_M_AXIS_DWIDTH-1:0] acc_data_q, acc_data_d;
    logic [R-1:0]               acc_keep_q, acc_keep_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [P_M_AXIS_DWIDTH-1:0] m_data_q, m_data_d;
    logic [R-1:0]               m_keep_q, m_keep_d;
    logic                       m_last_q, m_last_d;
    logic                       m_vld_q, m_vld_d;

    logic [R-1:0]               lane_sel_s;
    logic [P_M_AXIS_DWIDTH-1:0] merged_data_s;
    logic [R-1:0]               merged_keep_s;
    logic                       complete_s;
    logic                       s_ready_s;
    logic                       s_hs_s;
    logic                       m_hs_s;

    // Handshake decode, lane merge and next-state computation.
    always_comb begin
        lane_sel_s    = {{(R-1){1'b0}}, 1'b1} << cnt_q;
        merged_data_s = acc_data_q;
        merged_keep_s = acc_keep_q | lane_sel_s;
        for (int i = 0; i < R; i++) begin
            merged_data_s[i*P_S_AXIS_DWIDTH +: P_S_AXIS_DWIDTH] =
                lane_sel_s[i] ? s_axis_tdata
                              : acc_data_q[i*P_S_AXIS_DWIDTH +: P_S_AXIS_DWIDTH];
        end

        complete_s = (cnt_q == CW'(R - 1)) | s_axis_tlast;
        // Only a completing beat needs room in the output register.
        s_ready_s  = ~complete_s | ~m_vld_q | m_axis_tready;
        s_hs_s     = s_axis_tvalid & s_ready_s;
        m_hs_s     = m_vld_q & m_axis_tready;

        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        cnt_d      = cnt_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;
        m_vld_d    = m_vld_q;

        if (s_hs_s & complete_s) begin
            m_data_d   = merged_data_s;
            m_keep_d   = merged_keep_s;
            m_last_d   = s_axis_tlast;
            m_vld_d    = 1'b1;
            acc_data_d = '0;
            acc_keep_d = '0;
            cnt_d      = '0;
        end else if (s_hs_s) begin
            acc_data_d = merged_data_s;
            acc_keep_d = merged_keep_s;
            cnt_d      = cnt_q + CW'(1);
            m_vld_d    = m_hs_s ? 1'b0 : m_vld_q;
        end else begin
            m_vld_d    = m_hs_s ? 1'b0 : m_vld_q;
        end
    end

    // Accumulator and output register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_data_q <= '0;
            acc_keep_q <= '0;
            cnt_q      <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
            m_vld_q    <= 1'b0;
        end else begin
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            cnt_q      <= cnt_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
            m_vld_q    <= m_vld_d;
        end
    end

    assign s_axis_tready = s_ready_s;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tvalid = m_vld_q;

endmodule

// File: tb/tb_gn_axis_upsizer.sv
// Self-checking bench for gn_axis_upsizer: directed scenarios plus random traffic
// compared against a queue-based packing model.
module tb_gn_axis_upsizer;

    localparam int S = 8;
    localparam int M = 32;
    localparam int R = M / S;

    typedef struct {
        logic [M-1:0] d;
        logic [R-1:0] k;
        logic         l;
    } word_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [S-1:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [M-1:0] m_axis_tdata;
    logic [R-1:0] m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;

    int total = 0;
    int bad   = 0;

    logic [S-1:0] pend[$];
    word_t        outq[$];
    word_t        last_pop;
    logic         acc;

    gn_axis_upsizer #(.P_S_AXIS_DWIDTH(S), .P_M_AXIS_DWIDTH(M)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check just before the posedge, update model.
    task automatic step(input logic v, input logic [S-1:0] d, input logic l,
                        input logic mr, output logic accepted);
        logic  exp_rdy;
        word_t w;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        m_axis_tready = mr;
        #4;
        exp_rdy = !((pend.size() == R - 1) || l) || (outq.size() == 0) || mr;
        check_val("s_tready", s_axis_tready, exp_rdy);
        check_val("m_tvalid", m_axis_tvalid, outq.size() != 0);
        if (outq.size() != 0) begin
            check_val("m_tdata", m_axis_tdata, outq[0].d);
            check_val("m_tkeep", m_axis_tkeep, outq[0].k);
            check_val("m_tlast", m_axis_tlast, outq[0].l);
            if (mr) last_pop = outq.pop_front();
        end
        accepted = v && exp_rdy;
        if (accepted) begin
            pend.push_back(d);
            if (pend.size() == R || l) begin
                w.d = '0;
                for (int i = 0; i < pend.size(); i++) w.d = w.d | (M'(pend[i]) << (S * i));
                w.k = R'((1 << pend.size()) - 1);
                w.l = l;
                outq.push_back(w);
                pend.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [S-1:0] d, input logic l, input logic mr);
        logic a;
        int   tries;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 50) begin
            step(1'b1, d, l, mr, a);
            tries++;
        end
        check_val("send_timeout", a, 1'b1);
    endtask

    task automatic idle(input logic mr);
        logic a;
        step(1'b0, '0, 1'b0, mr, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
        check_val({tag, "_tdata"},  m_axis_tdata,  '0);
        check_val({tag, "_tkeep"},  m_axis_tkeep,  '0);
        check_val({tag, "_tlast"},  m_axis_tlast,  1'b0);
        check_val({tag, "_tready"}, s_axis_tready, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Full word
        send(8'h11, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b1);
        send(8'h44, 1'b0, 1'b1);
        idle(1'b1);
        check_val("full_word", {last_pop.l, last_pop.k, last_pop.d}, {1'b0, 4'hF, 32'h44332211});

        // Partial word closed by tlast, then next beat in lane 0
        send(8'hAA, 1'b0, 1'b1);
        send(8'hBB, 1'b0, 1'b1);
        send(8'hCC, 1'b1, 1'b1);
        idle(1'b1);
        check_val("partial_word", {last_pop.l, last_pop.k, last_pop.d}, {1'b1, 4'h7, 32'h00CCBBAA});
        send(8'h01, 1'b1, 1'b1);
        idle(1'b1);
        check_val("lane0_after", {last_pop.l, last_pop.k, last_pop.d}, {1'b1, 4'h1, 32'h00000001});

        // Single-beat packet
        send(8'h5A, 1'b1, 1'b1);
        idle(1'b1);
        check_val("single_beat", {last_pop.l, last_pop.k, last_pop.d}, {1'b1, 4'h1, 32'h0000005A});

        // Backpressure
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        send(8'h66, 1'b0, 1'b0);
        send(8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h88, 1'b0, 1'b0, acc);
            check_val("bp_stall", acc, 1'b0);
        end
        step(1'b1, 8'h88, 1'b0, 1'b1, acc);
        check_val("bp_accept", acc, 1'b1);
        check_val("bp_first", last_pop.d, 32'h44332211);
        idle(1'b1);
        check_val("bp_second", last_pop.d, 32'h88776655);
        check_val("bp_drained", outq.size(), 0);

        // Streaming
        for (int i = 0; i < 16; i++) begin
            step(1'b1, S'(i), 1'b0, 1'b1, acc);
            check_val("stream_acc", acc, 1'b1);
        end
        idle(1'b1);
        check_val("stream_last", last_pop.d, 32'h0F0E0D0C);

        // Reset mid-word
        send(8'hE1, 1'b0, 1'b1);
        send(8'hE2, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        pend.delete();
        outq.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) send(S'(i), 1'b0, 1'b1);
        idle(1'b1);
        check_val("after_reset", {last_pop.k, last_pop.d}, {4'hF, 32'h04030201});

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, S'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) < 7, acc);
        end
        for (int n = 0; n < 8; n++) idle(1'b1);
        check_val("final_drain", outq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
